// File: rtl/pwm_mixer_sched.sv
// pwm_mixer_sched: four voice requesters feed per-channel hold registers
// through a round-robin arbiter; once per PWM period a sequencer sums the
// unmuted holds into the next duty value, and a registered comparator turns
// the active duty into a pulse-width-modulated audio bit.
module pwm_mixer_sched #(
    parameter int CHANNELS     = 4,
    parameter int SAMPLE_WIDTH = 8,
    parameter int PWM_WIDTH    = 10
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             enable,
    input  logic [CHANNELS-1:0]              req,
    input  logic [CHANNELS*SAMPLE_WIDTH-1:0] sample,
    input  logic [CHANNELS-1:0]              mute,
    output logic [CHANNELS-1:0]              ack,
    output logic                             frame,
    output logic                             pwm
);

    localparam int IDX_W = $clog2(CHANNELS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Capture side
    logic [SAMPLE_WIDTH-1:0] hold_q [CHANNELS];
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [CHANNELS-1:0]     ack_q, ack_d;
    logic [CHANNELS-1:0]     eligible;
    logic                    grant_valid;
    logic [IDX_W-1:0]        grant_idx;
    logic [IDX_W-1:0]        cand;
    logic [SAMPLE_WIDTH-1:0] grant_sample;

    // Mix and PWM side
    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [PWM_WIDTH-1:0]    acc_q, acc_d;
    logic [PWM_WIDTH-1:0]    next_duty_q, next_duty_d;
    logic [PWM_WIDTH-1:0]    duty_q, duty_d;
    logic [PWM_WIDTH-1:0]    cnt_q, cnt_d;
    logic [PWM_WIDTH-1:0]    mix_term;
    logic                    cnt_wrap;
    logic                    frame_q, frame_d;
    logic                    pwm_q, pwm_d;

    // Round-robin search starting at ptr_q; a channel being acknowledged this
    // cycle still holds its req, so it is masked out to avoid a double grant.
    always_comb begin
        eligible    = req & ~ack_q;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            cand = ptr_q + IDX_W'(k);
            if (eligible[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
        grant_sample = sample[grant_idx*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        ack_d        = '0;
        ptr_d        = ptr_q;
        if (grant_valid) begin
            ack_d[grant_idx] = 1'b1;
            ptr_d            = grant_idx + IDX_W'(1);
        end
    end

    // Capture the granted sample and raise its ack one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            ack_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            ack_q <= ack_d;
            if (grant_valid) begin
                hold_q[grant_idx] <= grant_sample;
            end
        end
    end

    // Mix sequencer: one channel per cycle right after the period start,
    // then park the sum until the period ends.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        next_duty_d = next_duty_q;
        mix_term    = mute[idx_q] ? '0 : PWM_WIDTH'(hold_q[idx_q]);
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cnt_q == '0) begin
                        state_d = ACC;
                        idx_d   = '0;
                        acc_d   = '0;
                    end
                end
                ACC: begin
                    acc_d = acc_q + mix_term;
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d     = HOLD;
                        next_duty_d = acc_q + mix_term;
                    end
                end
                HOLD: begin
                    if (cnt_wrap) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Period counter, duty reload at wrap and the registered output bits.
    always_comb begin
        cnt_wrap = enable && (cnt_q == '1);
        cnt_d    = enable ? cnt_q + PWM_WIDTH'(1) : '0;
        duty_d   = cnt_wrap ? next_duty_q : duty_q;
        frame_d  = enable && (cnt_q == '0);
        pwm_d    = enable && (cnt_q < duty_q);
    end

    // State registers for the mix and PWM datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            next_duty_q <= '0;
            duty_q      <= '0;
            cnt_q       <= '0;
            frame_q     <= 1'b0;
            pwm_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            next_duty_q <= next_duty_d;
            duty_q      <= duty_d;
            cnt_q       <= cnt_d;
            frame_q     <= frame_d;
            pwm_q       <= pwm_d;
        end
    end

    assign ack   = ack_q;
    assign frame = frame_q;
    assign pwm   = pwm_q;

endmodule

// File: tb/tb_pwm_mixer_sched.sv
// Bench for pwm_mixer_sched: directed scenarios plus a random phase, all
// compared each cycle against a period-position model of capture, mix and PWM.
module tb_pwm_mixer_sched;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic        enable = 1'b0;
    logic [3:0]  req    = '0;
    logic [31:0] sample = '0;
    logic [3:0]  mute   = '0;
    logic [3:0]  ack;
    logic        frame;
    logic        pwm;

    always #5 clk = ~clk;

    pwm_mixer_sched #(
        .CHANNELS(4),
        .SAMPLE_WIDTH(8),
        .PWM_WIDTH(10)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .req(req),
        .sample(sample),
        .mute(mute),
        .ack(ack),
        .frame(frame),
        .pwm(pwm)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: position in the PWM period, stored samples and sums.
    int         cntM;
    int         dutyM;
    int         nextDutyM;
    int         sumM;
    int         ptrM;
    int         holdM [4];
    logic [3:0] expAck;
    logic [3:0] lastDrop;
    int         ackOrder [$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic resetModel();
        cntM      = 0;
        dutyM     = 0;
        nextDutyM = 0;
        sumM      = 0;
        ptrM      = 0;
        for (int i = 0; i < 4; i++) holdM[i] = 0;
        expAck    = '0;
        lastDrop  = '0;
        req       = '0;
    endtask

    // Drive rst_n low asynchronously, check outputs clear at once, release on a falling edge.
    task automatic doReset(input string tag);
        rst_n = 1'b0;
        #1;
        checkOutput({tag, "_ack"}, ack, 0);
        checkOutput({tag, "_frame"}, frame, 0);
        checkOutput({tag, "_pwm"}, pwm, 0);
        resetModel();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic raise(input int ch, input logic [7:0] value);
        req[ch]           = 1'b1;
        sample[ch*8 +: 8] = value;
    endtask

    // One clock: predict the next cycle's outputs, advance, compare, run requesters.
    task automatic applyStimulus();
        logic [3:0] eligible;
        logic [3:0] nextAck;
        logic [3:0] oldAck;
        logic       fN;
        logic       pN;
        int         g;
        int         c;
        eligible = req & ~expAck;
        nextAck  = '0;
        g        = -1;
        for (int k = 0; k < 4; k++) begin
            c = (ptrM + k) % 4;
            if (g < 0 && eligible[c]) g = c;
        end
        fN = enable && (cntM == 0);
        pN = enable && (cntM < dutyM);
        if (enable) begin
            if (cntM == 0) begin
                sumM = 0;
            end else if (cntM <= 4) begin
                if (!mute[cntM-1]) sumM = sumM + holdM[cntM-1];
                if (cntM == 4) nextDutyM = sumM;
            end
            if (cntM == 1023) dutyM = nextDutyM;
            cntM = (cntM + 1) % 1024;
        end else begin
            cntM = 0;
        end
        if (g >= 0) begin
            nextAck[g] = 1'b1;
            holdM[g]   = int'(sample[g*8 +: 8]);
            ptrM       = (g + 1) % 4;
        end
        @(posedge clk);
        @(negedge clk);
        oldAck = expAck;
        expAck = nextAck;
        checkOutput("ack", ack, expAck);
        checkOutput("frame", frame, fN);
        checkOutput("pwm", pwm, pN);
        for (int i = 0; i < 4; i++) if (ack[i] === 1'b1) ackOrder.push_back(i);
        req      = req & ~oldAck;
        lastDrop = oldAck;
    endtask

    task automatic waitFrame(input string tag);
        int n = 0;
        do begin
            applyStimulus();
            n++;
        end while (frame !== 1'b1 && n < 3000);
        checkOutput(tag, frame, 1);
    endtask

    task automatic stepUntilCnt(input int target);
        int n = 0;
        while (cntM != target && n < 3000) begin
            applyStimulus();
            n++;
        end
    endtask

    // Count pwm-high cycles across one period window starting at a frame cycle.
    task automatic measurePeriod(input string tag, input int expected);
        int highs;
        highs = (pwm === 1'b1) ? 1 : 0;
        repeat (1023) begin
            applyStimulus();
            if (pwm === 1'b1) highs++;
        end
        checkOutput(tag, highs, expected);
    endtask

    initial begin
        int a [4];
        int expSum;
        int ack0Pulses;
        int quietFrames;
        int quietHighs;
        int expOrderA [4];
        int expOrderB [5];

        expOrderA = '{0, 1, 2, 3};
        expOrderB = '{2, 3, 0, 1, 2};
        resetModel();
        #2;
        doReset("reset0");

        // Contention from pointer 0, then from pointer 3 after a lone grant to channel 2
        ackOrder.delete();
        for (int i = 0; i < 4; i++) raise(i, 8'(8'h11 * (i + 1)));
        repeat (6) applyStimulus();
        checkOutput("orderA_len", ackOrder.size(), 4);
        for (int i = 0; i < 4 && i < ackOrder.size(); i++) checkOutput("orderA", ackOrder[i], expOrderA[i]);
        ackOrder.delete();
        raise(2, 8'h5A);
        repeat (3) applyStimulus();
        for (int i = 0; i < 4; i++) raise(i, 8'($urandom));
        repeat (6) applyStimulus();
        checkOutput("orderB_len", ackOrder.size(), 5);
        for (int i = 0; i < 5 && i < ackOrder.size(); i++) checkOutput("orderB", ackOrder[i], expOrderB[i]);

        // Single channel at 0x80
        applyStimulus();
        doReset("reset1");
        raise(0, 8'h80);
        ack0Pulses = 0;
        repeat (3) begin
            applyStimulus();
            if (ack[0] === 1'b1) ack0Pulses++;
        end
        checkOutput("ack0_pulses", ack0Pulses, 1);
        enable = 1'b1;
        waitFrame("frame_p0");
        waitFrame("frame_p1");
        measurePeriod("single_0x80", 128);

        // Full-scale mix, then mute channel 3
        for (int i = 0; i < 4; i++) raise(i, 8'hFF);
        repeat (6) applyStimulus();
        waitFrame("frame_full1");
        waitFrame("frame_full2");
        measurePeriod("full_mix", 1020);
        mute = 4'b1000;
        waitFrame("frame_mute1");
        waitFrame("frame_mute2");
        measurePeriod("mute3_mix", 765);

        // Channel 1 captured in the same cycle the sequencer reads it
        mute = 4'b0000;
        stepUntilCnt(2);
        raise(1, 8'h10);
        applyStimulus();
        waitFrame("frame_col1");
        measurePeriod("collision_old", 1020);
        waitFrame("frame_col2");
        measurePeriod("collision_new", 781);

        // Reset during the accumulate window, then enable toggling
        stepUntilCnt(2);
        checkOutput("pre_reset_pwm", pwm, 1);
        doReset("reset_mid");
        applyStimulus();
        checkOutput("first_frame", frame, 1);
        expSum = 0;
        for (int i = 0; i < 4; i++) begin
            a[i]   = int'($urandom_range(255));
            expSum = expSum + a[i];
            raise(i, 8'(a[i]));
        end
        repeat (6) applyStimulus();
        waitFrame("frame_en1");
        waitFrame("frame_en2");
        enable      = 1'b0;
        quietFrames = 0;
        quietHighs  = 0;
        repeat (50) begin
            applyStimulus();
            if (frame !== 1'b0) quietFrames++;
            if (pwm !== 1'b0) quietHighs++;
        end
        checkOutput("disabled_frames", quietFrames, 0);
        checkOutput("disabled_pwm", quietHighs, 0);
        enable = 1'b1;
        waitFrame("reenable_frame");
        measurePeriod("duty_kept", expSum);

        // Random traffic, mutes and occasional enable changes
        repeat (4000) begin
            for (int i = 0; i < 4; i++) begin
                if (!req[i] && !lastDrop[i]) begin
                    if ($urandom_range(7) == 0) raise(i, 8'($urandom));
                    else sample[i*8 +: 8] = 8'($urandom);
                end
            end
            if ($urandom_range(15) == 0) mute = 4'($urandom);
            if ($urandom_range(499) == 0) enable = ~enable;
            applyStimulus();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
